outport_uart_tx: RTL and testbench

OUTPORT_UART_TX -- requirements
Module: outport_uart_tx

---
 rtl/outport_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_outport_uart_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/outport_uart_tx.sv
// Byte-wide transmit UART behind a 9x8 core outport: a small FIFO feeding an
// 8N1/8N2 serialiser whose bit time is set by G_BAUD_DIV.
module outport_uart_tx #(
    parameter int G_BAUD_DIV   = 868,
    parameter int G_FIFO_DEPTH = 16,
    parameter int G_NSTOP      = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_full,
    output logic       o_busy,
    output logic       o_overflow,
    output logic       o_tx
);

    localparam int         AW          = $clog2(G_FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C    = (AW + 1)'(G_FIFO_DEPTH);
    localparam logic [AW:0] COUNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [15:0] BAUD_RELOAD = 16'(G_BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST   = 3'(G_NSTOP - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem_r [G_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [1:0]    state_r;
    logic [15:0]   baud_cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          overflow_r;

    logic full_s;
    logic empty_s;
    logic bit_end_s;
    logic push_s;
    logic pop_s;

    // FIFO status and end-of-bit decode from registered state
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        empty_s   = (count_r == COUNT_ZERO);
        bit_end_s = (baud_cnt_r == 16'd0);
    end

    // Accept a write only when there was room before this edge
    always_comb begin
        push_s = 1'b0;
        if (i_wr && !full_s && !i_rst) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Pop when leaving IDLE or at the last stop-bit cycle with data waiting
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !empty_s;
            ST_STOP: pop_s = bit_end_s && (bit_idx_r == STOP_LAST) && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Status outputs read as zero while reset is held
    always_comb begin
        o_full = 1'b0;
        o_busy = 1'b0;
        if (i_rst) begin
            o_full = 1'b0;
            o_busy = 1'b0;
        end else begin
            o_full = full_s;
            o_busy = (state_r != ST_IDLE) || !empty_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers do
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= COUNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (i_wr && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Serialiser: start bit, 8 data bits LSB first, G_NSTOP stop bits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (!empty_s) begin
                        shift_r    <= mem_r[rd_ptr_r];
                        state_r    <= ST_START;
                        tx_r       <= 1'b0;
                        baud_cnt_r <= BAUD_RELOAD;
                        bit_idx_r  <= 3'd0;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_r    <= ST_DATA;
                        tx_r       <= shift_r[0];
                        bit_idx_r  <= 3'd0;
                        baud_cnt_r <= BAUD_RELOAD;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= BAUD_RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r   <= ST_STOP;
                            tx_r      <= 1'b1;
                            bit_idx_r <= 3'd0;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= shift_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        // bit_idx_r counts stop bits here
                        if (bit_idx_r == STOP_LAST) begin
                            bit_idx_r <= 3'd0;
                            if (!empty_s) begin
                                shift_r    <= mem_r[rd_ptr_r];
                                state_r    <= ST_START;
                                tx_r       <= 1'b0;
                                baud_cnt_r <= BAUD_RELOAD;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            bit_idx_r  <= bit_idx_r + 3'd1;
                            baud_cnt_r <= BAUD_RELOAD;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx       = tx_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Bench for outport_uart_tx: one-stop and two-stop instances driven in lockstep
// and compared every cycle against a frame-timing reference model.
module tb_outport_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] data;

    logic full0, busy0, ovf0, tx0;
    logic full1, busy1, ovf1, tx1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one set per instance (0: one stop bit, 1: two)
    logic [7:0] mq [2][$];
    logic [7:0] m_byte [2];
    int         m_t    [2];
    bit         m_in   [2];
    bit         m_ovf  [2];

    outport_uart_tx #(.G_BAUD_DIV(DIV), .G_FIFO_DEPTH(DEPTH), .G_NSTOP(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(data),
        .o_full(full0), .o_busy(busy0), .o_overflow(ovf0), .o_tx(tx0)
    );

    outport_uart_tx #(.G_BAUD_DIV(DIV), .G_FIFO_DEPTH(DEPTH), .G_NSTOP(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data(data),
        .o_full(full1), .o_busy(busy1), .o_overflow(ovf1), .o_tx(tx1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int k);
        return (9 + ((k == 0) ? 1 : 2)) * DIV;
    endfunction

    // Line level at cycle t of a frame carrying byte b
    function automatic logic line_bit(input logic [7:0] b, input int t);
        int slot;
        slot = t / DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot - 1];
        return 1'b1;
    endfunction

    task automatic model_edge(input int k, input logic r, input logic w, input logic [7:0] d);
        int pre;
        if (r) begin
            mq[k].delete();
            m_in[k]  = 1'b0;
            m_t[k]   = 0;
            m_ovf[k] = 1'b0;
        end else begin
            pre = mq[k].size();
            if (m_in[k]) begin
                m_t[k]++;
                if (m_t[k] == frame_len(k)) m_in[k] = 1'b0;
            end
            if (!m_in[k] && pre > 0) begin
                m_byte[k] = mq[k].pop_front();
                m_in[k]   = 1'b1;
                m_t[k]    = 0;
            end
            if (w) begin
                if (pre < DEPTH) mq[k].push_back(d);
                else m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_tx, exp_busy, exp_full;
        for (int k = 0; k < 2; k++) begin
            exp_tx   = m_in[k] ? line_bit(m_byte[k], m_t[k]) : 1'b1;
            exp_busy = !rst && (m_in[k] || mq[k].size() > 0);
            exp_full = !rst && (mq[k].size() == DEPTH);
            if (k == 0) begin
                check_val("tx0",   {31'd0, tx0},   {31'd0, exp_tx});
                check_val("busy0", {31'd0, busy0}, {31'd0, exp_busy});
                check_val("full0", {31'd0, full0}, {31'd0, exp_full});
                check_val("ovf0",  {31'd0, ovf0},  {31'd0, m_ovf[0]});
            end else begin
                check_val("tx1",   {31'd0, tx1},   {31'd0, exp_tx});
                check_val("busy1", {31'd0, busy1}, {31'd0, exp_busy});
                check_val("full1", {31'd0, full1}, {31'd0, exp_full});
                check_val("ovf1",  {31'd0, ovf1},  {31'd0, m_ovf[1]});
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare mid-cycle
    task automatic step(input logic r, input logic w, input logic [7:0] d);
        rst  = r;
        wr   = w;
        data = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, r, w, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 1'b0; m_t[k] = 0; m_ovf[k] = 1'b0; m_byte[k] = 8'h00;
        end
        rst = 1'b1; wr = 1'b0; data = 8'h00;

        // Reset state, including a write ignored while in reset
        do_reset();
        check_val("rst_tx", {31'd0, tx0}, 32'd1);
        check_val("rst_busy", {31'd0, busy0}, 32'd0);
        idle(3);

        // Single byte A5
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b0, 8'h00);
        check_val("start_bit", {31'd0, tx0}, 32'd0);
        idle(50);

        // Back-to-back 00 then FF
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        idle(100);

        // Fill and overflow with six consecutive writes
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 8'(8'h10 + i));
            if (i == 4) check_val("full_after_fill", {31'd0, full0}, 32'd1);
        end
        check_val("ovf_after_drop", {31'd0, ovf0}, 32'd1);
        idle(5 * 44 + 10);
        check_val("ovf_sticky", {31'd0, ovf0}, 32'd1);

        // Write while full on the same edge as a pop: dropped, count drops
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h61 + i));
        idle(36);
        step(1'b0, 1'b1, 8'hEE);
        check_val("pop_drop_full", {31'd0, full0}, 32'd0);
        check_val("pop_drop_ovf", {31'd0, ovf0}, 32'd1);
        idle(5 * 44);

        // Reset during data bit 3 with two bytes queued
        do_reset();
        step(1'b0, 1'b1, 8'hC3);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'h96);
        idle(15);
        step(1'b1, 1'b0, 8'h00);
        check_val("midrst_tx", {31'd0, tx0}, 32'd1);
        check_val("midrst_busy", {31'd0, busy0}, 32'd0);
        check_val("midrst_ovf", {31'd0, ovf0}, 32'd0);
        idle(100);
        check_val("midrst_quiet", {31'd0, tx0}, 32'd1);

        // Two-stop instance carries 80 in a 44-cycle frame (model covers dut1)
        step(1'b0, 1'b1, 8'h80);
        idle(60);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
                 8'($urandom_range(0, 255)));
        end
        idle(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
